// File: rtl/error_monitor_bank.sv
// Bank of sticky error latches read group-by-group, with clear-on-read,
// first-error capture and a saturating count of edges that bring new errors.
module error_monitor_bank #(
    parameter  int N_CH  = 26,
    parameter  int GRP   = 7,
    parameter  int CNT_W = 4,
    localparam int NG    = (N_CH + GRP - 1) / GRP,
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int SEL_W = (NG > 1) ? $clog2(NG) : 1
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             V1,
    input  logic [N_CH-1:0]  ERR_IN,
    input  logic [N_CH-1:0]  MASK,
    input  logic             RD_STB,
    input  logic [SEL_W-1:0] RD_SEL,
    input  logic             CLR_EN,
    input  logic             CNT_CLR,
    output logic [N_CH-1:0]  EM_N,
    output logic [NG-1:0]    EMRG,
    output logic [GRP-1:0]   RD_DATA,
    output logic             RD_VLD,
    output logic             FIRST_VLD,
    output logic [IDX_W-1:0] FIRST_IDX,
    output logic [CNT_W-1:0] ERR_CNT
);
    localparam int PAD_W = NG * GRP;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  l_q, l_d;
    logic [NG-1:0]    emrg_q, emrg_d;
    logic [GRP-1:0]   rd_data_q, rd_data_d;
    logic             rd_vld_q, rd_vld_d;
    logic             first_vld_q, first_vld_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]  set_v, clr_mask, base;
    logic [PAD_W-1:0] l_pad;
    logic             rd_ok, any_new;
    int               sel_i;

    always_comb begin
        set_v   = ERR_IN & ~MASK;
        rd_ok   = (int'(RD_SEL) < NG);
        sel_i   = rd_ok ? int'(RD_SEL) : 0;
        l_pad   = '0;
        l_pad[N_CH-1:0] = l_q;
        clr_mask = '0;
        for (int k = 0; k < N_CH; k++)
            if (V1 && RD_STB && CLR_EN && rd_ok && (k / GRP == sel_i))
                clr_mask[k] = 1'b1;
        base    = l_q & ~clr_mask;
        // a channel cleared and re-set on the same edge is not a new error
        any_new = |(set_v & ~l_q);

        l_d         = l_q;
        rd_data_d   = rd_data_q;
        rd_vld_d    = 1'b0;
        first_idx_d = first_idx_q;
        cnt_d       = cnt_q;
        if (V1) begin
            l_d = base | set_v;
            if (RD_STB) begin
                rd_vld_d  = 1'b1;
                rd_data_d = rd_ok ? l_pad[sel_i*GRP +: GRP] : '0;
            end
            // capture whenever the surviving bank is empty: covers both an idle
            // bank and one being cleared out on the same edge
            if (base == '0 && set_v != '0)
                for (int k = N_CH - 1; k >= 0; k--)
                    if (set_v[k]) first_idx_d = IDX_W'(k);
            if (CNT_CLR)
                cnt_d = CNT_W'(any_new);
            else if (any_new && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end
        first_vld_d = |l_d;

        emrg_d = '0;
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < GRP; i++)
                if (g * GRP + i < N_CH && l_d[g*GRP+i]) emrg_d[g] = 1'b1;
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            l_q         <= '0;
            emrg_q      <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
            cnt_q       <= '0;
        end else begin
            l_q         <= l_d;
            emrg_q      <= emrg_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            first_vld_q <= first_vld_d;
            first_idx_q <= first_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign EM_N      = ~l_q;
    assign EMRG      = emrg_q;
    assign RD_DATA   = rd_data_q;
    assign RD_VLD    = rd_vld_q;
    assign FIRST_VLD = first_vld_q;
    assign FIRST_IDX = first_idx_q;
    assign ERR_CNT   = cnt_q;
endmodule
